panel_line_arbiter: RTL and testbench

- Shares the single ledpanel control port (ctrl_wr/ctrl_addr/ctrl_wdat/ctrl_done) between up to 4 line-write requesters, e.g. the Baby CPU sequencer, a CI/status highlighter and a debug overlay.
- Each request is one 32-pixel panel line: 5-bit line number, 32-bit value, 24-bit colour.
- The block arbitrates round-robin and serialises the request into 32 single-pixel panel writes.
- It signals acceptance and completion back to the requester that owns the request.

---
 rtl/panel_line_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_panel_line_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_line_arbiter.sv
// panel_line_arbiter: shares the single ledpanel control port between NREQ
// line-write requesters. Requests are granted round-robin; each granted line
// (5-bit line number, 32-bit pattern, 24-bit colour) is serialised into 32
// single-pixel panel writes with a per-pixel ctrl_done handshake and a
// HOLD_MAX-cycle abandon timer.
// Build macro PANEL_CLEAR_EN: after reset, blank all 1024 pixels before the
// first request is accepted.
module panel_line_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned HOLD_MAX = 255
) (
    input  logic                 clk100,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    req_line,
    input  logic [32*NREQ-1:0]   req_value,
    input  logic [24*NREQ-1:0]   req_color,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 timeout,
    output logic [3:0]           ctrl_wr,
    output logic                 ctrl_rd,
    output logic [15:0]          ctrl_addr,
    output logic [31:0]          ctrl_wdat,
    input  logic                 ctrl_done
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

`ifdef PANEL_CLEAR_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIN, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t          state, state_nx;
    logic [GW-1:0]   last, last_nx;
    logic [NREQ-1:0] gnt, gnt_nx;
    logic [4:0]      col, col_nx;
    logic [4:0]      line_q, line_nx;
    logic [31:0]     value_q, value_nx;
    logic [23:0]     color_q, color_nx;
    logic [HW-1:0]   hold, hold_nx;
    logic [NREQ-1:0] ack_nx, done_nx;
    logic            timeout_nx;
    logic [3:0]      ctrl_wr_nx;
    logic [15:0]     ctrl_addr_nx;
    logic [31:0]     ctrl_wdat_nx;
    logic [15:0]     pix_addr;

    logic            pick_ok;
    logic [GW-1:0]   pick;
    logic [NREQ-1:0] pick_oh;
    logic [4:0]      pick_line;
    logic [31:0]     pick_value;
    logic [23:0]     pick_color;

`ifdef PANEL_CLEAR_EN
    logic            clr_mode, clr_mode_nx;
    logic [9:0]      clr_cnt, clr_cnt_nx;
`endif

    assign busy    = (state != IDLE);
    assign ctrl_rd = 1'b0;

    // Panel byte address of pixel (col, line); the panel's x axis runs 31..0.
    assign pix_addr = (({11'd0, col} << 5) + 16'd31 - {11'd0, line_q}) << 2;

    // Round-robin pick: first active request above 'last', then wrap to the bottom.
    always_comb begin
        pick_ok    = 1'b0;
        pick       = '0;
        pick_oh    = '0;
        pick_line  = '0;
        pick_value = '0;
        pick_color = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_ok && req[i] && (i > 32'(last))) begin
                pick_ok    = 1'b1;
                pick       = GW'(i);
                pick_oh[i] = 1'b1;
                pick_line  = req_line[5*i +: 5];
                pick_value = req_value[32*i +: 32];
                pick_color = req_color[24*i +: 24];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_ok && req[i] && (i <= 32'(last))) begin
                pick_ok    = 1'b1;
                pick       = GW'(i);
                pick_oh[i] = 1'b1;
                pick_line  = req_line[5*i +: 5];
                pick_value = req_value[32*i +: 32];
                pick_color = req_color[24*i +: 24];
            end
        end
    end

    // Next-state and next-output logic for the grant/serialise sequence.
    always_comb begin
        state_nx     = state;
        last_nx      = last;
        gnt_nx       = gnt;
        col_nx       = col;
        line_nx      = line_q;
        value_nx     = value_q;
        color_nx     = color_q;
        hold_nx      = hold;
        ack_nx       = '0;
        done_nx      = '0;
        timeout_nx   = 1'b0;
        ctrl_wr_nx   = ctrl_wr;
        ctrl_addr_nx = ctrl_addr;
        ctrl_wdat_nx = ctrl_wdat;
`ifdef PANEL_CLEAR_EN
        clr_mode_nx  = clr_mode;
        clr_cnt_nx   = clr_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    gnt_nx   = pick_oh;
                    last_nx  = pick;
                    line_nx  = pick_line;
                    value_nx = pick_value;
                    color_nx = pick_color;
                    col_nx   = '0;
                    ack_nx   = pick_oh;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                ctrl_wr_nx   = 4'b0111;
                ctrl_addr_nx = pix_addr;
                ctrl_wdat_nx = value_q[col] ? {8'h00, color_q} : '0;
                hold_nx      = '0;
                state_nx     = WAIT;
            end
            WAIT: begin
                // A done arriving on the final hold cycle wins over the timeout.
                if (ctrl_done || (hold == HW'(HOLD_MAX - 1))) begin
                    ctrl_wr_nx = '0;
                    timeout_nx = ~ctrl_done;
`ifdef PANEL_CLEAR_EN
                    if (clr_mode) begin
                        if (clr_cnt == 10'd1023) begin
                            clr_mode_nx = 1'b0;
                            state_nx    = IDLE;
                        end else begin
                            clr_cnt_nx = clr_cnt + 10'd1;
                            state_nx   = CLEAR;
                        end
                    end else
`endif
                    if (col == 5'd31) begin
                        state_nx = FIN;
                    end else begin
                        col_nx   = col + 5'd1;
                        state_nx = ISSUE;
                    end
                end else begin
                    hold_nx = hold + 1'b1;
                end
            end
            FIN: begin
                done_nx  = gnt;
                state_nx = IDLE;
            end
`ifdef PANEL_CLEAR_EN
            CLEAR: begin
                ctrl_wr_nx   = 4'b0111;
                ctrl_addr_nx = {4'd0, clr_cnt, 2'b00};
                ctrl_wdat_nx = '0;
                hold_nx      = '0;
                state_nx     = WAIT;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state     <= RESET_STATE;
            last      <= GW'(NREQ - 1);
            gnt       <= '0;
            col       <= '0;
            line_q    <= '0;
            value_q   <= '0;
            color_q   <= '0;
            hold      <= '0;
            ack       <= '0;
            done      <= '0;
            timeout   <= 1'b0;
            ctrl_wr   <= '0;
            ctrl_addr <= '0;
            ctrl_wdat <= '0;
`ifdef PANEL_CLEAR_EN
            clr_mode  <= 1'b1;
            clr_cnt   <= '0;
`endif
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            gnt       <= gnt_nx;
            col       <= col_nx;
            line_q    <= line_nx;
            value_q   <= value_nx;
            color_q   <= color_nx;
            hold      <= hold_nx;
            ack       <= ack_nx;
            done      <= done_nx;
            timeout   <= timeout_nx;
            ctrl_wr   <= ctrl_wr_nx;
            ctrl_addr <= ctrl_addr_nx;
            ctrl_wdat <= ctrl_wdat_nx;
`ifdef PANEL_CLEAR_EN
            clr_mode  <= clr_mode_nx;
            clr_cnt   <= clr_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_panel_line_arbiter.sv
// Self-checking bench for panel_line_arbiter: randomized line requests checked
// against a pixel-list reference model, with a ledpanel responder model.
`timescale 1ns/1ps
module tb_panel_line_arbiter;

    localparam int unsigned NREQ     = 2;
    localparam int unsigned HOLD_MAX = 16;

    logic                clk100 = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     req;
    logic [5*NREQ-1:0]   req_line;
    logic [32*NREQ-1:0]  req_value;
    logic [24*NREQ-1:0]  req_color;
    logic [NREQ-1:0]     ack, done;
    logic                busy, timeout;
    logic [3:0]          ctrl_wr;
    logic                ctrl_rd;
    logic [15:0]         ctrl_addr;
    logic [31:0]         ctrl_wdat;
    logic                ctrl_done;

    panel_line_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
        .clk100(clk100), .resetn(resetn), .req(req), .req_line(req_line),
        .req_value(req_value), .req_color(req_color), .ack(ack), .done(done),
        .busy(busy), .timeout(timeout), .ctrl_wr(ctrl_wr), .ctrl_rd(ctrl_rd),
        .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat), .ctrl_done(ctrl_done)
    );

    always #5 clk100 = ~clk100;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int panel_mode = 0;   // 0: random latency 1..4, >0: fixed latency, <0: never answer
    bit noise = 1'b0;     // spurious ctrl_done while no write is outstanding
    int wcnt = 0;
    int cur_lat = 1;
    logic [3:0] prev_wr = '0;
    logic exp_busy_rst;
    logic [15:0] exp_addr_rst;

    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  we_q[$];
    int ack_q[$], done_q[$], to_q[$];

    // Reference: pixel address and data of column col for a requested line.
    function automatic logic [15:0] exp_addr(int col, int line);
        int a;
        a = ((col * 32) + 31 - line) * 4;
        return a[15:0];
    endfunction

    function automatic logic [31:0] exp_wdat(logic [31:0] v, logic [23:0] c, int col);
        return v[col] ? {8'h00, c} : 32'h0;
    endfunction

    function automatic void clear_logs();
        wa_q.delete(); wd_q.delete(); we_q.delete();
        ack_q.delete(); done_q.delete(); to_q.delete();
    endfunction

    // Ledpanel responder and output logger, both away from the active edge.
    always @(negedge clk100) begin
        cyc++;
        if (ctrl_wr != 4'b0 && prev_wr == 4'b0) begin
            wa_q.push_back(ctrl_addr); wd_q.push_back(ctrl_wdat); we_q.push_back(ctrl_wr);
        end
        prev_wr = ctrl_wr;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) ack_q.push_back(i);
            if (done[i]) done_q.push_back(i);
        end
        if (timeout) to_q.push_back(cyc);
        ctrl_done = 1'b0;
        if (ctrl_wr != 4'b0) begin
            wcnt++;
            if (wcnt == cur_lat) ctrl_done = 1'b1;
        end else begin
            wcnt = 0;
            cur_lat = (panel_mode == 0) ? int'($urandom_range(1, 4)) : panel_mode;
            if (noise && $urandom_range(0, 3) == 0) ctrl_done = 1'b1;
        end
    end

    task automatic do_reset(output bit ok);
        req = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk100);
        resetn = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk100);
            if (!busy) begin ok = 1'b1; break; end
        end
        clear_logs();
    endtask

    // One requester issues one line; all 32 writes and the pulses are checked.
    task automatic run_line(input int r, input logic [4:0] ln, input logic [31:0] v,
                            input logic [23:0] c, input int exp_to, input string tag);
        bit ok;
        logic [NREQ-1:0] exp_ack;
        clear_logs();
        req_line[5*r +: 5] = ln;
        req_value[32*r +: 32] = v;
        req_color[24*r +: 24] = c;
        req[r] = 1'b1;
        @(negedge clk100);
        exp_ack = '0; exp_ack[r] = 1'b1;
        vectors++;
        if (ack !== exp_ack) begin miscompares++; $display("FAIL %s ack_latency: got %b want %b", tag, ack, exp_ack); end
        req[r] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 32 * (HOLD_MAX + 4) + 40; k++) begin
            if (done_q.size() >= 1) begin ok = 1'b1; break; end
            @(negedge clk100);
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL %s done_wait: got no done want done[%0d]", tag, r); end
        repeat (3) @(negedge clk100);
        vectors++;
        if (wa_q.size() != 32) begin miscompares++; $display("FAIL %s write_count: got %0d want 32", tag, wa_q.size()); end
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (wa_q[k] !== exp_addr(k, int'(ln))) begin miscompares++;
                $display("FAIL %s addr col%0d: got %h want %h", tag, k, wa_q[k], exp_addr(k, int'(ln))); end
            vectors++;
            if (wd_q[k] !== exp_wdat(v, c, k)) begin miscompares++;
                $display("FAIL %s wdat col%0d: got %h want %h", tag, k, wd_q[k], exp_wdat(v, c, k)); end
            vectors++;
            if (we_q[k] !== 4'b0111) begin miscompares++;
                $display("FAIL %s wr col%0d: got %b want 0111", tag, k, we_q[k]); end
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != r) begin miscompares++;
            $display("FAIL %s done_pulse: got %0d pulses want 1 on %0d", tag, done_q.size(), r); end
        vectors++;
        if (ack_q.size() != 1) begin miscompares++; $display("FAIL %s ack_count: got %0d want 1", tag, ack_q.size()); end
        vectors++;
        if (to_q.size() != exp_to) begin miscompares++; $display("FAIL %s timeout_count: got %0d want %0d", tag, to_q.size(), exp_to); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL %s busy_end: got %b want 0", tag, busy); end
    endtask

    task automatic test_reset;
        bit ok;
        do_reset(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL reset_settle: got busy want idle"); end
        vectors++; if (ack !== '0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", ack); end
        vectors++; if (done !== '0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        vectors++; if (ctrl_wr !== 4'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", ctrl_wr); end
        vectors++; if (ctrl_rd !== 1'b0) begin miscompares++; $display("FAIL reset_rd: got %b want 0", ctrl_rd); end
        vectors++; if (ctrl_addr !== exp_addr_rst) begin miscompares++; $display("FAIL reset_addr: got %h want %h", ctrl_addr, exp_addr_rst); end
        vectors++; if (ctrl_wdat !== 32'h0) begin miscompares++; $display("FAIL reset_wdat: got %h want 0", ctrl_wdat); end
    endtask

    task automatic test_single;
        run_line(0, 5'd0, 32'h80000001, 24'h00FF00, 0, "single");
        vectors++; if (wa_q[0] !== 16'h007C) begin miscompares++; $display("FAIL single_col0_addr: got %h want 007c", wa_q[0]); end
        vectors++; if (wd_q[0] !== 32'h0000FF00) begin miscompares++; $display("FAIL single_col0_wdat: got %h want 0000ff00", wd_q[0]); end
        vectors++; if (wa_q[1] !== 16'h00FC) begin miscompares++; $display("FAIL single_col1_addr: got %h want 00fc", wa_q[1]); end
        vectors++; if (wd_q[1] !== 32'h0) begin miscompares++; $display("FAIL single_col1_wdat: got %h want 0", wd_q[1]); end
        vectors++; if (wa_q[31] !== 16'h0FFC) begin miscompares++; $display("FAIL single_col31_addr: got %h want 0ffc", wa_q[31]); end
        vectors++; if (wd_q[31] !== 32'h0000FF00) begin miscompares++; $display("FAIL single_col31_wdat: got %h want 0000ff00", wd_q[31]); end
    endtask

    task automatic test_address;
        run_line(0, 5'd5, 32'h00000004, 24'hFF0000, 0, "addr");
        vectors++; if (wa_q[2] !== 16'h0168) begin miscompares++; $display("FAIL addr_col2: got %h want 0168", wa_q[2]); end
        vectors++; if (wd_q[2] !== 32'h00FF0000) begin miscompares++; $display("FAIL addr_col2_wdat: got %h want 00ff0000", wd_q[2]); end
        run_line(1, 5'd31, $urandom, 24'($urandom), 0, "addr_line31");
    endtask

    // A request dropped before its ack leaves no trace.
    task automatic test_withdraw;
        bit ok;
        clear_logs();
        req_line[4:0] = 5'd9; req_value[31:0] = $urandom; req_color[23:0] = 24'($urandom);
        req[0] = 1'b1;
        @(negedge clk100);
        req[0] = 1'b0;
        repeat (4) @(negedge clk100);
        req[1] = 1'b1;
        repeat (3) @(negedge clk100);
        req[1] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done_q.size() >= 1) begin ok = 1'b1; break; end
            @(negedge clk100);
        end
        repeat (6) @(negedge clk100);
        vectors++; if (!ok) begin miscompares++; $display("FAIL withdraw_done: got no done want done"); end
        vectors++; if (ack_q.size() != 1) begin miscompares++; $display("FAIL withdraw_acks: got %0d want 1", ack_q.size()); end
        vectors++; if (wa_q.size() != 32) begin miscompares++; $display("FAIL withdraw_writes: got %0d want 32", wa_q.size()); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL withdraw_busy: got %b want 0", busy); end
    endtask

    // Both requesters held high from reset: grants must alternate 0,1,0,1.
    task automatic test_contention;
        bit ok;
        int order[$];
        logic [4:0] el[$];
        logic [31:0] ev[$];
        logic [23:0] ec[$];
        int rr_last, exp_g;
        do_reset(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL cont_reset: got busy want idle"); end
        req_line = 10'($urandom); req_value = {$urandom, $urandom}; req_color = 48'({$urandom, $urandom});
        req = '1;
        ok = 1'b0;
        for (int k = 0; k < 4 * 32 * 6 + 60; k++) begin
            @(negedge clk100);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    order.push_back(i);
                    el.push_back(req_line[5*i +: 5]);
                    ev.push_back(req_value[32*i +: 32]);
                    ec.push_back(req_color[24*i +: 24]);
                    req_line[5*i +: 5] = 5'($urandom);
                    req_value[32*i +: 32] = $urandom;
                    req_color[24*i +: 24] = 24'($urandom);
                    if (order.size() == 4) req = '0;
                end
            end
            if (done_q.size() >= 4) begin ok = 1'b1; break; end
        end
        req = '0;
        repeat (3) @(negedge clk100);
        vectors++; if (!ok) begin miscompares++; $display("FAIL cont_done_wait: got %0d dones want 4", done_q.size()); end
        vectors++; if (order.size() != 4) begin miscompares++; $display("FAIL cont_grants: got %0d want 4", order.size()); end
        rr_last = NREQ - 1;
        for (int n = 0; n < 4; n++) begin
            exp_g = (rr_last + 1) % NREQ;
            vectors++;
            if (order[n] != exp_g) begin miscompares++; $display("FAIL cont_order%0d: got %0d want %0d", n, order[n], exp_g); end
            vectors++;
            if (done_q[n] != exp_g) begin miscompares++; $display("FAIL cont_done%0d: got %0d want %0d", n, done_q[n], exp_g); end
            rr_last = exp_g;
        end
        vectors++; if (wa_q.size() != 128) begin miscompares++; $display("FAIL cont_writes: got %0d want 128", wa_q.size()); end
        for (int k = 0; k < 128 && k / 32 < el.size(); k++) begin
            vectors++;
            if (wa_q[k] !== exp_addr(k % 32, int'(el[k/32])) || wd_q[k] !== exp_wdat(ev[k/32], ec[k/32], k % 32)) begin
                miscompares++;
                $display("FAIL cont_pix%0d: got %h/%h want %h/%h", k, wa_q[k], wd_q[k],
                         exp_addr(k % 32, int'(el[k/32])), exp_wdat(ev[k/32], ec[k/32], k % 32));
            end
        end
    endtask

    task automatic test_timeout;
        int d;
        panel_mode = -1;
        run_line(0, 5'($urandom), $urandom, 24'($urandom), 32, "timeout");
        for (int i = 1; i < 32 && i < to_q.size(); i++) begin
            d = to_q[i] - to_q[i-1];
            vectors++;
            if (d < int'(HOLD_MAX) || d > int'(HOLD_MAX) + 1) begin miscompares++;
                $display("FAIL timeout_spacing%0d: got %0d want %0d..%0d", i, d, HOLD_MAX, HOLD_MAX + 1); end
        end
        panel_mode = 0;
    endtask

    task automatic test_hold_boundary;
        panel_mode = HOLD_MAX;
        run_line(1, 5'($urandom), $urandom, 24'($urandom), 0, "hold_exact");
        panel_mode = HOLD_MAX + 1;
        run_line(0, 5'($urandom), $urandom, 24'($urandom), 32, "hold_late");
        panel_mode = 0;
    endtask

    task automatic test_mid_reset;
        bit ok;
        clear_logs();
        req_line[4:0] = 5'd17; req_value[31:0] = 32'hFFFFFFFF; req_color[23:0] = 24'h123456;
        req[0] = 1'b1;
        @(negedge clk100);
        req[0] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (wa_q.size() >= 11) begin ok = 1'b1; break; end
            @(negedge clk100);
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_progress: got %0d writes want 11", wa_q.size()); end
        resetn = 1'b0;
        @(negedge clk100);
        vectors++; if (ctrl_wr !== 4'b0) begin miscompares++; $display("FAIL midrst_wr: got %b want 0", ctrl_wr); end
        vectors++; if (busy !== exp_busy_rst) begin miscompares++; $display("FAIL midrst_busy: got %b want %b", busy, exp_busy_rst); end
        @(negedge clk100);
        resetn = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk100);
            if (!busy) begin ok = 1'b1; break; end
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL midrst_settle: got busy want idle"); end
        vectors++; if (done_q.size() != 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d want 0", done_q.size()); end
        run_line(1, 5'd3, $urandom, 24'($urandom), 0, "after_reset");
    endtask

    task automatic test_random;
        noise = 1'b1;
        for (int n = 0; n < 8; n++)
            run_line(int'($urandom_range(0, NREQ - 1)), 5'($urandom), $urandom, 24'($urandom), 0, "random");
        noise = 1'b0;
    endtask

`ifdef PANEL_CLEAR_EN
    task automatic test_clear;
        bit ok;
        req = '0;
        resetn = 1'b0;
        req_line[4:0] = 5'd1; req_value[31:0] = $urandom; req_color[23:0] = 24'($urandom);
        req[0] = 1'b1;
        repeat (3) @(negedge clk100);
        clear_logs();
        resetn = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk100);
            if (ack[0]) begin ok = 1'b1; break; end
        end
        req[0] = 1'b0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL clear_ack: got none want ack[0]"); end
        vectors++; if (wa_q.size() != 1024) begin miscompares++; $display("FAIL clear_count: got %0d want 1024", wa_q.size()); end
        for (int k = 0; k < 1024; k++) begin
            vectors++;
            if (wa_q[k] !== 16'(k * 4) || wd_q[k] !== 32'h0) begin miscompares++;
                $display("FAIL clear_pix%0d: got %h/%h want %h/0", k, wa_q[k], wd_q[k], 16'(k * 4)); end
        end
        repeat (32 * 8) @(negedge clk100);
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
`ifdef PANEL_CLEAR_EN
        exp_busy_rst = 1'b1;
        exp_addr_rst = 16'h0FFC;
`else
        exp_busy_rst = 1'b0;
        exp_addr_rst = 16'h0000;
`endif
        resetn = 1'b0; req = '0; req_line = '0; req_value = '0; req_color = '0; ctrl_done = 1'b0;
        test_reset();
        test_single();
        test_address();
        test_withdraw();
        test_contention();
        test_timeout();
        test_hold_boundary();
        test_mid_reset();
        test_random();
`ifdef PANEL_CLEAR_EN
        test_clear();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
